comp: RTL and testbench

COMP -- requirements
Module: comp

---
 rtl/comp.sv | 148 ++++++++++++++
 tb/tb_comp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comp.sv
// ---------------------------------------------------------------------------
// comp -- registered magnitude comparator built on a two-level carry-lookahead
// subtractor.  Computes D = A + ~B + 1 and registers:
//   zero : D == 0          (A equals B)
//   cout : carry-out       (A >= B, unsigned)
//   sign : D[WIDTH-1]
// Optional feature macro COMP_OVF_EN adds two more registered outputs:
//   ovf  : signed overflow of A - B
//   slt  : signed A < B
// WIDTH must be a multiple of 4 in the range 4..64.
// ---------------------------------------------------------------------------
module comp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             zero,
    output logic             cout,
    output logic             sign
`ifdef COMP_OVF_EN
    ,
    output logic             ovf,
    output logic             slt
`endif
);

    // Number of 4-bit lookahead groups.
    localparam int NG = WIDTH / 4;

    // Inverted subtrahend and per-bit generate/propagate.
    logic [WIDTH-1:0] b_inv;
    logic [WIDTH-1:0] bit_g;
    logic [WIDTH-1:0] bit_p;

    // Group generate/propagate and carries into each group.
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;

    // Carry into every bit position; carry[WIDTH] is the carry-out.
    logic [WIDTH:0]   carry;

    // Difference A - B.
    logic [WIDTH-1:0] diff;

    // Per-bit generate/propagate of A + ~B.
    always_comb begin
        b_inv = ~data2;
        bit_g = data1 & b_inv;
        bit_p = data1 ^ b_inv;
    end

    // Group generate/propagate for each 4-bit slice.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int g = 0; g < NG; g++) begin
            grp_g[g] = bit_g[4*g+3]
                     | (bit_p[4*g+3] & bit_g[4*g+2])
                     | (bit_p[4*g+3] & bit_p[4*g+2] & bit_g[4*g+1])
                     | (bit_p[4*g+3] & bit_p[4*g+2] & bit_p[4*g+1] & bit_g[4*g]);
            grp_p[g] = bit_p[4*g+3] & bit_p[4*g+2] & bit_p[4*g+1] & bit_p[4*g];
        end
    end

    // Second-level lookahead: each group carry is a flat sum of products of
    // group generates/propagates and the constant carry-in of 1 that turns
    // ~B into -B.
    always_comb begin : group_lookahead
        logic acc;
        logic term;
        grp_c    = '0;
        grp_c[0] = 1'b1;
        acc      = 1'b0;
        term     = 1'b0;
        for (int i = 0; i < NG; i++) begin
            acc = 1'b1;
            for (int j = 0; j <= i; j++) begin
                acc = acc & grp_p[j];
            end
            for (int j = 0; j <= i; j++) begin
                term = grp_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & grp_p[k];
                end
                acc = acc | term;
            end
            grp_c[i+1] = acc;
        end
    end

    // First-level lookahead: carries inside each group derived from the
    // group carry-in and the bit generates/propagates of that group.
    always_comb begin : bit_lookahead
        logic acc;
        logic term;
        carry    = '0;
        acc      = 1'b0;
        term     = 1'b0;
        for (int g = 0; g < NG; g++) begin
            carry[4*g] = grp_c[g];
            for (int k = 1; k < 4; k++) begin
                acc = grp_c[g];
                for (int j = 0; j < k; j++) begin
                    acc = acc & bit_p[4*g+j];
                end
                for (int j = 0; j < k; j++) begin
                    term = bit_g[4*g+j];
                    for (int m = j + 1; m < k; m++) begin
                        term = term & bit_p[4*g+m];
                    end
                    acc = acc | term;
                end
                carry[4*g+k] = acc;
            end
        end
        carry[WIDTH] = grp_c[NG];
    end

    // Sum bits of the subtraction.
    always_comb begin
        diff = bit_p ^ carry[WIDTH-1:0];
    end

    // Output registers; reset clears every flag immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero <= 1'b0;
            cout <= 1'b0;
            sign <= 1'b0;
`ifdef COMP_OVF_EN
            ovf  <= 1'b0;
            slt  <= 1'b0;
`endif
        end else begin
            zero <= ~|diff;
            cout <= carry[WIDTH];
            sign <= diff[WIDTH-1];
`ifdef COMP_OVF_EN
            ovf  <= carry[WIDTH-1] ^ carry[WIDTH];
            slt  <= diff[WIDTH-1] ^ (carry[WIDTH-1] ^ carry[WIDTH]);
`endif
        end
    end

endmodule

// File: tb/tb_comp.sv
// ---------------------------------------------------------------------------
// tb_comp -- self-checking bench for comp.  Expected flags come from a
// behavioural model, are queued when operands are driven and popped when the
// registered result appears one clock later.
// ---------------------------------------------------------------------------
module tb_comp;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             zero;
    logic             cout;
    logic             sign;
`ifdef COMP_OVF_EN
    logic             ovf;
    logic             slt;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             zero;
        logic             cout;
        logic             sign;
        logic             ovf;
        logic             slt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    comp #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .data1 (data1),
        .data2 (data2),
        .zero  (zero),
        .cout  (cout),
        .sign  (sign)
`ifdef COMP_OVF_EN
        ,
        .ovf   (ovf),
        .slt   (slt)
`endif
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour written with plain arithmetic.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t           e;
        logic [WIDTH:0] full;
        full   = {1'b0, a} - {1'b0, b};
        e.a    = a;
        e.b    = b;
        e.zero = (a == b);
        e.cout = (a >= b);
        e.sign = full[WIDTH-1];
        e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        e.slt  = ($signed(a) < $signed(b));
        return e;
    endfunction

    // Drive one operand pair on the falling edge and queue its expectation.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        data1 = a;
        data2 = b;
        sb.push_back(model(a, b));
    endtask

    // Reset held: every output must be 0.
    task automatic test_reset();
        rst   = 1'b1;
        data1 = '0;
        data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (zero !== 1'b0) $display("[TB] FAIL reset_zero got=%b want=0", zero);
        else passes++;
        checks++;
        if (cout !== 1'b0) $display("[TB] FAIL reset_cout got=%b want=0", cout);
        else passes++;
        checks++;
        if (sign !== 1'b0) $display("[TB] FAIL reset_sign got=%b want=0", sign);
        else passes++;
`ifdef COMP_OVF_EN
        checks++;
        if (ovf !== 1'b0) $display("[TB] FAIL reset_ovf got=%b want=0", ovf);
        else passes++;
        checks++;
        if (slt !== 1'b0) $display("[TB] FAIL reset_slt got=%b want=0", slt);
        else passes++;
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Named vectors plus equality / B=0 / sign-boundary corner cases.
    task automatic test_directed();
        logic [WIDTH-1:0] va[14];
        logic [WIDTH-1:0] vb[14];
        exp_t             e;
        va = '{32'h1, 32'h1, 32'h3, 32'h8000_0000, 32'h0, 32'h0, 32'h5,
               32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
               32'hFFFF_FFFF, 32'h0000_FFFF, 32'h1234_5678};
        vb = '{32'h1, 32'h2, 32'h2, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0,
               32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
               32'h0, 32'h0001_0000, 32'h1234_5678};
        for (int i = 0; i < 14; i++) begin
            applyStimulus(va[i], vb[i]);
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL directed_queue got=empty want=entry");
            end else begin
                passes++;
                e = sb.pop_front();
                checks++;
                if (zero !== e.zero) $display("[TB] FAIL directed_zero a=%h b=%h got=%b want=%b", e.a, e.b, zero, e.zero);
                else passes++;
                checks++;
                if (cout !== e.cout) $display("[TB] FAIL directed_cout a=%h b=%h got=%b want=%b", e.a, e.b, cout, e.cout);
                else passes++;
                checks++;
                if (sign !== e.sign) $display("[TB] FAIL directed_sign a=%h b=%h got=%b want=%b", e.a, e.b, sign, e.sign);
                else passes++;
`ifdef COMP_OVF_EN
                checks++;
                if (ovf !== e.ovf) $display("[TB] FAIL directed_ovf a=%h b=%h got=%b want=%b", e.a, e.b, ovf, e.ovf);
                else passes++;
                checks++;
                if (slt !== e.slt) $display("[TB] FAIL directed_slt a=%h b=%h got=%b want=%b", e.a, e.b, slt, e.slt);
                else passes++;
`endif
            end
        end
    endtask

    // A new random pair every clock, biased toward equal and zero operands.
    task automatic test_back_to_back();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        exp_t             e;
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 6)
                0: b = a;
                1: b = '0;
                2: b = a ^ (32'h1 << $urandom_range(31, 0));
                default: ;
            endcase
            applyStimulus(a, b);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (zero !== e.zero) $display("[TB] FAIL b2b_zero a=%h b=%h got=%b want=%b", e.a, e.b, zero, e.zero);
            else passes++;
            checks++;
            if (cout !== e.cout) $display("[TB] FAIL b2b_cout a=%h b=%h got=%b want=%b", e.a, e.b, cout, e.cout);
            else passes++;
            checks++;
            if (sign !== e.sign) $display("[TB] FAIL b2b_sign a=%h b=%h got=%b want=%b", e.a, e.b, sign, e.sign);
            else passes++;
`ifdef COMP_OVF_EN
            checks++;
            if (ovf !== e.ovf) $display("[TB] FAIL b2b_ovf a=%h b=%h got=%b want=%b", e.a, e.b, ovf, e.ovf);
            else passes++;
            checks++;
            if (slt !== e.slt) $display("[TB] FAIL b2b_slt a=%h b=%h got=%b want=%b", e.a, e.b, slt, e.slt);
            else passes++;
`endif
        end
    endtask

    // Reset between edges clears outputs at once; no stale result after release.
    task automatic test_mid_reset();
        exp_t e;
        applyStimulus(32'h1, 32'h2);
        @(posedge clk);
        #2;
        rst   = 1'b1;
        data1 = 32'h5;
        data2 = 32'h5;
        sb.delete();
        #1;
        checks++;
        if ({zero, cout, sign} !== 3'b000) $display("[TB] FAIL midrst_async got=%b%b%b want=000", zero, cout, sign);
        else passes++;
`ifdef COMP_OVF_EN
        checks++;
        if ({ovf, slt} !== 2'b00) $display("[TB] FAIL midrst_async_ovf got=%b%b want=00", ovf, slt);
        else passes++;
`endif
        @(posedge clk);
        #1;
        checks++;
        if ({zero, cout, sign} !== 3'b000) $display("[TB] FAIL midrst_held got=%b%b%b want=000", zero, cout, sign);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(model(data1, data2));
        #1;
        checks++;
        if ({zero, cout, sign} !== 3'b000) $display("[TB] FAIL midrst_stale got=%b%b%b want=000", zero, cout, sign);
        else passes++;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (zero !== e.zero) $display("[TB] FAIL midrst_zero got=%b want=%b", zero, e.zero);
        else passes++;
        checks++;
        if (cout !== e.cout) $display("[TB] FAIL midrst_cout got=%b want=%b", cout, e.cout);
        else passes++;
        checks++;
        if (sign !== e.sign) $display("[TB] FAIL midrst_sign got=%b want=%b", sign, e.sign);
        else passes++;
    endtask

    // Test sequence.
    initial begin
        $display("[TB] starting comp bench");
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
